// File: rtl/gpx_multi_rd.sv
// gpx_multi_rd: multi-channel GPX readout sequencer.
//
// Per-channel "event done" pulses are queued as pending requests. Channels
// are granted round-robin, and each grant streams RD_LEN sequential buffer
// read addresses under a ready/valid handshake. A second event on a channel
// whose request is still waiting sets a sticky overrun flag.
//
// Ports:
//   clk_fpga           system clock, rising edge
//   rst                synchronous active-high reset
//   in_re_start        synchronous abort/restart, same effect as rst
//   in_gpx_event_done  per-channel capture-complete pulses
//   in_rd_ready        downstream accepts the current beat
//   out_rd_e           beat valid
//   out_rd_addr        beat address 0..RD_LEN-1, local to out_rd_ch
//   out_rd_ch          channel being read, stable for the burst
//   out_rd_sof         first beat of burst
//   out_rd_eof         last beat of burst
//   out_frame_done     one-cycle pulse after the last beat is accepted
//   out_busy           high while granting or reading
//   out_overrun        sticky per-channel overrun flags
module gpx_multi_rd #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned RD_LEN = 300
) (
    input  logic              clk_fpga,
    input  logic              rst,
    input  logic              in_re_start,
    input  logic [CH_NUM-1:0] in_gpx_event_done,
    input  logic              in_rd_ready,
    output logic              out_rd_e,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic [CH_W-1:0]   out_rd_ch,
    output logic              out_rd_sof,
    output logic              out_rd_eof,
    output logic              out_frame_done,
    output logic              out_busy,
    output logic [CH_NUM-1:0] out_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_READ
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RD_LEN - 1);
    localparam logic [CH_W-1:0]   LAST_INIT = CH_W'(CH_NUM - 1);

    state_t              state_q, state_d;
    logic [CH_NUM-1:0]   pending_q, pending_d;
    logic [CH_NUM-1:0]   overrun_q, overrun_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_e_q, rd_e_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;

    logic [CH_W-1:0]     sel;
    logic                found;
    logic [CH_NUM-1:0]   grant_clr;

    // Round-robin pick: first pending channel after the last granted one.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= CH_NUM; k++) begin
            int unsigned pos;
            pos = 32'(last_q) + k;
            if (pos >= CH_NUM) begin
                pos = pos - CH_NUM;
            end
            if (!found && pending_q[CH_W'(pos)]) begin
                found = 1'b1;
                sel   = CH_W'(pos);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        ch_d         = ch_q;
        addr_d       = addr_q;
        rd_e_d       = rd_e_q;
        sof_d        = sof_q;
        eof_d        = eof_q;
        frame_done_d = 1'b0;
        grant_clr    = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d   = ST_GRANT;
                    ch_d      = sel;
                    last_d    = sel;
                    grant_clr = CH_NUM'(1) << sel;
                end
            end
            ST_GRANT: begin
                state_d = ST_READ;
                rd_e_d  = 1'b1;
                addr_d  = '0;
                sof_d   = 1'b1;
                eof_d   = (RD_LEN == 1);
            end
            ST_READ: begin
                if (rd_e_q && in_rd_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d      = ST_IDLE;
                        rd_e_d       = 1'b0;
                        sof_d        = 1'b0;
                        eof_d        = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        sof_d  = 1'b0;
                        eof_d  = ((addr_q + ADDR_W'(1)) == LAST_ADDR);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new event wins over the grant clear; only a request that stays
        // pending through this edge counts as an overrun.
        pending_d = (pending_q & ~grant_clr) | in_gpx_event_done;
        overrun_d = overrun_q | (in_gpx_event_done & pending_q & ~grant_clr);
        busy_d    = (state_d != ST_IDLE);

        if (in_re_start) begin
            state_d      = ST_IDLE;
            pending_d    = '0;
            overrun_d    = '0;
            last_d       = LAST_INIT;
            ch_d         = '0;
            addr_d       = '0;
            rd_e_d       = 1'b0;
            sof_d        = 1'b0;
            eof_d        = 1'b0;
            frame_done_d = 1'b0;
            busy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            overrun_q    <= '0;
            last_q       <= LAST_INIT;
            ch_q         <= '0;
            addr_q       <= '0;
            rd_e_q       <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            last_q       <= last_d;
            ch_q         <= ch_d;
            addr_q       <= addr_d;
            rd_e_q       <= rd_e_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign out_rd_e       = rd_e_q;
    assign out_rd_addr    = addr_q;
    assign out_rd_ch      = ch_q;
    assign out_rd_sof     = sof_q;
    assign out_rd_eof     = eof_q;
    assign out_frame_done = frame_done_q;
    assign out_busy       = busy_q;
    assign out_overrun    = overrun_q;

endmodule

// File: tb/tb_gpx_multi_rd.sv
// Bench for gpx_multi_rd: a 4-channel RD_LEN=300 instance checked every cycle
// against a transaction-level reference model, plus a 1-channel RD_LEN=1
// instance driven from a cycle table.
module tb_gpx_multi_rd;

    localparam int CH  = 4;
    localparam int LEN = 300;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    // main instance
    logic       rst, rs, rdy;
    logic [3:0] ev;
    logic       e, sof, eof, done, busy;
    logic [1:0] ch;
    logic [8:0] addr;
    logic [3:0] ovr;

    gpx_multi_rd #(.CH_NUM(4), .CH_W(2), .ADDR_W(9), .RD_LEN(300)) u_dut (
        .clk_fpga(clk), .rst(rst), .in_re_start(rs), .in_gpx_event_done(ev),
        .in_rd_ready(rdy), .out_rd_e(e), .out_rd_addr(addr), .out_rd_ch(ch),
        .out_rd_sof(sof), .out_rd_eof(eof), .out_frame_done(done),
        .out_busy(busy), .out_overrun(ovr)
    );

    // single-channel, single-beat instance
    logic s_rst, s_rs, s_ev, s_rdy;
    logic s_e, s_sof, s_eof, s_done, s_busy, s_ch, s_addr, s_ovr;

    gpx_multi_rd #(.CH_NUM(1), .CH_W(1), .ADDR_W(1), .RD_LEN(1)) u_small (
        .clk_fpga(clk), .rst(s_rst), .in_re_start(s_rs), .in_gpx_event_done(s_ev),
        .in_rd_ready(s_rdy), .out_rd_e(s_e), .out_rd_addr(s_addr), .out_rd_ch(s_ch),
        .out_rd_sof(s_sof), .out_rd_eof(s_eof), .out_frame_done(s_done),
        .out_busy(s_busy), .out_overrun(s_ovr)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;   // ready: 0 always, 1 pattern 1,0,0,1, 2 random
    bit m_en   = 1'b0;

    // Reference model: a request set, the channel being served (-1 = none),
    // whether beats are flowing and which beat is offered.
    bit [3:0] m_pend  = '0;
    bit [3:0] m_ovr   = '0;
    int       m_cur   = -1;
    bit       m_valid = 1'b0;
    int       m_beat  = 0;
    bit       m_done  = 1'b0;
    int       m_ch    = 0;
    int       m_last  = CH - 1;

    // observed traffic
    int beats = 0;
    int log_n = 0;
    int log_q [64];

    always @(posedge clk) begin : model
        logic [1:0] c;
        bit         got;
        int         clr;
        if (!rst && !rs && e === 1'b1 && rdy) beats++;
        if (done === 1'b1 && log_n < 64) begin
            log_q[log_n] = int'(ch);
            log_n++;
        end
        if (rst || rs) begin
            m_pend = '0; m_ovr = '0; m_cur = -1; m_valid = 1'b0;
            m_beat = 0; m_done = 1'b0; m_ch = 0; m_last = CH - 1;
        end else begin
            clr    = -1;
            m_done = 1'b0;
            if (m_cur < 0) begin
                got = 1'b0;
                for (int k = 1; k <= CH; k++) begin
                    c = 2'((m_last + k) % CH);
                    if (!got && m_pend[c]) begin
                        got   = 1'b1;
                        m_cur = int'(c);
                    end
                end
                if (got) begin
                    m_ch = m_cur; m_last = m_cur; clr = m_cur;
                end
            end else if (!m_valid) begin
                m_valid = 1'b1;
                m_beat  = 0;
            end else if (rdy) begin
                if (m_beat == LEN - 1) begin
                    m_valid = 1'b0; m_cur = -1; m_done = 1'b1;
                end else begin
                    m_beat++;
                end
            end
            for (int i = 0; i < CH; i++) begin
                c = 2'(i);
                if (ev[c]) begin
                    if (m_pend[c] && i != clr) m_ovr[c] = 1'b1;
                    m_pend[c] = 1'b1;
                end else if (i == clr) begin
                    m_pend[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, compare against the model, set ready.
    task automatic tick();
        logic [19:0] act, exp;
        @(negedge clk);
        cyc++;
        if (m_en) begin
            act = {e, sof, eof, done, busy, ch, ovr, (e === 1'b1) ? addr : 9'd0};
            exp = {m_valid, m_valid && m_beat == 0, m_valid && m_beat == LEN - 1,
                   m_done, m_cur >= 0, 2'(m_ch), m_ovr, m_valid ? 9'(m_beat) : 9'd0};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cycle %0d got %h want %h", cyc, act, exp);
            end
        end
        case (mode)
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b1;
        endcase
    endtask

    task automatic pulse(input logic [3:0] m);
        ev = m;
        tick();
        ev = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rs = 1'b0; ev = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        int quiet;
        n = 0; quiet = 0;
        while (quiet < 3 && n < limit) begin
            tick();
            n++;
            if (busy === 1'b1) quiet = 0; else quiet++;
        end
        chk(name, quiet, 3);
    endtask

    typedef struct packed {
        logic rst, rs, ev, rdy;
        logic e, sof, eof, done, busy, ov;
    } vec_t;

    vec_t tbl [28];

    initial begin
        int b0, l0, n, busy_seen;
        bit found;

        // rows: {rst, re_start, event, ready}, {e, sof, eof, done, busy, overrun}
        tbl[0]  = {4'b1001, 6'b000000};
        tbl[1]  = {4'b0011, 6'b000000};
        tbl[2]  = {4'b0001, 6'b000010};
        tbl[3]  = {4'b0001, 6'b111010};
        tbl[4]  = {4'b0001, 6'b000100};
        tbl[5]  = {4'b0001, 6'b000000};
        tbl[6]  = {4'b0011, 6'b000000};
        tbl[7]  = {4'b0001, 6'b000010};
        tbl[8]  = {4'b0000, 6'b111010};
        tbl[9]  = {4'b0000, 6'b111010};
        tbl[10] = {4'b1010, 6'b000000};
        tbl[11] = {4'b0001, 6'b000000};
        tbl[12] = {4'b0001, 6'b000000};
        tbl[13] = {4'b0011, 6'b000000};
        tbl[14] = {4'b0011, 6'b000010};
        tbl[15] = {4'b0001, 6'b111010};
        tbl[16] = {4'b0001, 6'b000100};
        tbl[17] = {4'b0001, 6'b000010};
        tbl[18] = {4'b0001, 6'b111010};
        tbl[19] = {4'b0001, 6'b000100};
        tbl[20] = {4'b0001, 6'b000000};
        tbl[21] = {4'b0011, 6'b000000};
        tbl[22] = {4'b0011, 6'b000010};
        tbl[23] = {4'b0010, 6'b111011};
        tbl[24] = {4'b0001, 6'b000101};
        tbl[25] = {4'b0001, 6'b000011};
        tbl[26] = {4'b0101, 6'b000000};
        tbl[27] = {4'b0001, 6'b000000};

        rst = 1'b1; rs = 1'b0; ev = '0; rdy = 1'b1;
        s_rst = 1'b1; s_rs = 1'b0; s_ev = 1'b0; s_rdy = 1'b1;

        // single-beat instance, cycle table
        for (int i = 0; i < 28; i++) begin
            logic [7:0] sact, sexp;
            s_rst = tbl[i].rst; s_rs = tbl[i].rs; s_ev = tbl[i].ev; s_rdy = tbl[i].rdy;
            tick();
            sact = {s_e, s_sof, s_eof, s_done, s_busy, s_ovr, s_ch, s_addr};
            sexp = {tbl[i].e, tbl[i].sof, tbl[i].eof, tbl[i].done, tbl[i].busy, tbl[i].ov, 2'b00};
            checks++;
            if (sact !== sexp) begin
                errors++;
                $display("FAIL small_row %0d got %b want %b", i, sact, sexp);
            end
        end

        // reset state
        m_en = 1'b1;
        do_reset();
        chk("reset_outputs", 32'({e, sof, eof, done, busy, ch, ovr, addr}), 0);

        // single event on ch2, latency and full burst
        b0 = beats; l0 = log_n;
        ev = 4'b0100;
        tick();
        ev = '0;
        chk("t1_e_edge1", 32'(e), 0);
        tick();
        chk("t1_busy_edge2", 32'(busy), 1);
        chk("t1_e_edge2", 32'(e), 0);
        tick();
        chk("t1_e_edge3", 32'(e), 1);
        chk("t1_ch", 32'(ch), 2);
        chk("t1_sof", 32'(sof), 1);
        wait_idle(400, "t1_idle");
        chk("t1_beats", beats - b0, 300);
        chk("t1_frames", log_n - l0, 1);
        chk("t1_frame_ch", log_q[l0], 2);

        // back-pressure pattern
        do_reset();
        mode = 1;
        b0 = beats; l0 = log_n;
        pulse(4'b0010);
        wait_idle(1500, "t2_idle");
        chk("t2_beats", beats - b0, 300);
        chk("t2_frames", log_n - l0, 1);
        chk("t2_frame_ch", log_q[l0], 1);
        mode = 0;

        // all channels at once, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            l0 = log_n;
            pulse(4'b1111);
            wait_idle(1500, "t3_idle");
            chk("t3_frames", log_n - l0, 4);
            for (int i = 0; i < 4; i++) chk("t3_order", log_q[l0 + i], i);
        end
        chk("t3_overrun", 32'(ovr), 0);

        // overrun on a waiting channel, re-request of the active channel
        do_reset();
        l0 = log_n;
        pulse(4'b1000);
        repeat (10) tick();
        pulse(4'b0010);
        repeat (10) tick();
        pulse(4'b0010);
        repeat (5) tick();
        chk("t4_overrun_ch1", 32'(ovr), 2);
        pulse(4'b1000);
        tick();
        chk("t4_no_overrun_ch3", 32'(ovr), 2);
        wait_idle(1500, "t4_idle");
        chk("t4_frames", log_n - l0, 3);
        chk("t4_first", log_q[l0], 3);
        chk("t4_second", log_q[l0 + 1], 1);
        chk("t4_third", log_q[l0 + 2], 3);
        chk("t4_overrun_end", 32'(ovr), 2);

        // abort mid-burst with a simultaneous event
        do_reset();
        pulse(4'b0100);
        repeat (5) tick();
        pulse(4'b0010);
        pulse(4'b0010);
        chk("t5_overrun_set", 32'(ovr), 2);
        found = 1'b0; n = 0;
        while (!found && n < 400) begin
            if (e === 1'b1 && addr == 9'd150) found = 1'b1;
            else begin tick(); n++; end
        end
        chk("t5_addr150_reached", 32'(found), 1);
        rs = 1'b1; ev = 4'b0001;
        tick();
        rs = 1'b0; ev = '0;
        chk("t5_outputs_cleared", 32'({e, sof, eof, done, busy, ch, ovr, addr}), 0);
        l0 = log_n; busy_seen = 0;
        repeat (30) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
        end
        chk("t5_no_busy", busy_seen, 0);
        chk("t5_no_frames", log_n - l0, 0);

        // randomized traffic against the model
        do_reset();
        mode = 2;
        l0 = log_n;
        repeat (5000) begin
            ev = '0;
            if ($urandom_range(0, 29) == 0) ev = 4'($urandom_range(1, 15));
            rs = ($urandom_range(0, 2499) == 0);
            tick();
        end
        ev = '0; rs = 1'b0; mode = 0;
        wait_idle(3000, "rand_idle");
        chk("rand_frames_seen", 32'(log_n - l0 > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
